sram_share_ctrl: RTL and testbench

- Sequencer/arbiter that owns the single port of the 8x4 digit SRAM used by the memory display app.
- Shares the port between three clients:
  - write client: switch entry storing a decoded digit;
  - pair-read client: two-address sum feeding the BCD/7-seg path;
  - scan engine: on request, sums all entries into a total.
- Sits between the user-input logic and a synchronous-read SRAM; its outputs drive the binary-to-BCD display chain.

---
 rtl/sram_share_pkg.sv | 25 ++
 rtl/sram_share_ctrl_if.sv | 40 ++++
 rtl/prio_arb3.sv | 22 ++
 rtl/sram_share_ctrl.sv | 146 ++++++++++++++
 tb/tb_sram_share_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_share_pkg.sv
// Shared state encoding, default geometry and derived widths for the
// SRAM-sharing sequencer.
package sram_share_pkg;

    localparam int DEF_AW = 3;
    localparam int DEF_DW = 4;
    localparam int PSW    = DEF_DW + 1;
    localparam int SSW    = DEF_DW + DEF_AW;

    // Client slots in the arbiter vectors; lower index wins.
    localparam int CL_WR = 0;
    localparam int CL_PR = 1;
    localparam int CL_SC = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        PR_A   = 3'd2,
        PR_B   = 3'd3,
        PR_C   = 3'd4,
        SC_RD  = 3'd5,
        SC_ACC = 3'd6
    } state_t;

endpackage

// File: rtl/sram_share_ctrl_if.sv
// Client and SRAM-side signals of the shared-port sequencer; the controller
// takes the slave view, the surrounding logic and memory the master view.
interface sram_share_ctrl_if
    import sram_share_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic              WR_REQ;
    logic [AW-1:0]     WR_ADDR;
    logic [DW-1:0]     WR_DATA;
    logic              WR_ACK;
    logic              PR_REQ;
    logic [AW-1:0]     PR_A1;
    logic [AW-1:0]     PR_A2;
    logic              PR_ACK;
    logic [DW:0]       PR_SUM;
    logic              SUM_START;
    logic              SUM_BUSY;
    logic              SUM_DONE;
    logic [DW+AW-1:0]  SUM_OUT;
    logic              MEM_WE;
    logic              MEM_RE;
    logic [AW-1:0]     MEM_ADDR;
    logic [DW-1:0]     MEM_WDATA;
    logic [DW-1:0]     MEM_RDATA;

    modport master (
        output WR_REQ, WR_ADDR, WR_DATA, PR_REQ, PR_A1, PR_A2, SUM_START, MEM_RDATA,
        input  WR_ACK, PR_ACK, PR_SUM, SUM_BUSY, SUM_DONE, SUM_OUT,
               MEM_WE, MEM_RE, MEM_ADDR, MEM_WDATA
    );

    modport slave (
        input  WR_REQ, WR_ADDR, WR_DATA, PR_REQ, PR_A1, PR_A2, SUM_START, MEM_RDATA,
        output WR_ACK, PR_ACK, PR_SUM, SUM_BUSY, SUM_DONE, SUM_OUT,
               MEM_WE, MEM_RE, MEM_ADDR, MEM_WDATA
    );

endinterface

// File: rtl/prio_arb3.sv
// Fixed-priority three-way grant (bit 0 highest); a set lock bit removes
// that client from contention for the current cycle.
module prio_arb3 (
    input  logic [2:0] req,
    input  logic [2:0] lock,
    output logic [2:0] gnt
);

    logic [2:0] eligible;

    always_comb begin
        eligible = req & ~lock;
        gnt      = 3'b000;
        if (eligible[0])
            gnt = 3'b001;
        else if (eligible[1])
            gnt = 3'b010;
        else if (eligible[2])
            gnt = 3'b100;
    end

endmodule

// File: rtl/sram_share_ctrl.sv
// Owns the single synchronous-read SRAM port and time-shares it between
// digit writes, two-address sums and a yielding whole-memory scan.
module sram_share_ctrl
    import sram_share_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic             CLK,
    input  logic             RST,
    sram_share_ctrl_if.slave bus
);

    localparam int PW = DW + 1;
    localparam int SW = DW + AW;
    localparam logic [AW-1:0] LAST_IDX = '1;

    state_t        state;
    logic          scan_pending;
    logic [AW-1:0] scan_idx;
    logic [SW-1:0] acc;
    logic [AW-1:0] a1_q;
    logic [AW-1:0] a2_q;
    logic [DW-1:0] op1;
    logic [2:0]    lock_q;
    logic          pr_ack_q;
    logic [PW-1:0] pr_sum_q;
    logic          sum_done_q;
    logic [SW-1:0] sum_out_q;
    logic [2:0]    req;
    logic [2:0]    gnt;
    logic [SW-1:0] rdata_ext;

    assign req       = {scan_pending, bus.PR_REQ, bus.WR_REQ};
    assign rdata_ext = {{AW{1'b0}}, bus.MEM_RDATA};

    prio_arb3 u_arb (
        .req  (req),
        .lock (lock_q),
        .gnt  (gnt)
    );

    // A client just served sees its lock bit for one cycle so a REQ that has
    // not yet dropped cannot win the following IDLE arbitration.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            scan_pending <= 1'b0;
            scan_idx     <= '0;
            acc          <= '0;
            a1_q         <= '0;
            a2_q         <= '0;
            op1          <= '0;
            lock_q       <= 3'b000;
            pr_ack_q     <= 1'b0;
            pr_sum_q     <= '0;
            sum_done_q   <= 1'b0;
            sum_out_q    <= '0;
        end else begin
            lock_q     <= 3'b000;
            pr_ack_q   <= 1'b0;
            sum_done_q <= 1'b0;
            if (bus.SUM_START && !scan_pending) begin
                scan_pending <= 1'b1;
                scan_idx     <= '0;
                acc          <= '0;
            end
            case (state)
                IDLE: begin
                    if (gnt[CL_WR]) begin
                        state <= WRITE;
                    end else if (gnt[CL_PR]) begin
                        state <= PR_A;
                        a1_q  <= bus.PR_A1;
                        a2_q  <= bus.PR_A2;
                    end else if (gnt[CL_SC]) begin
                        state <= SC_RD;
                    end
                end
                WRITE: begin
                    lock_q[CL_WR] <= 1'b1;
                    state         <= IDLE;
                end
                PR_A: state <= PR_B;
                PR_B: begin
                    op1   <= bus.MEM_RDATA;
                    state <= PR_C;
                end
                PR_C: begin
                    pr_sum_q      <= {1'b0, op1} + {1'b0, bus.MEM_RDATA};
                    pr_ack_q      <= 1'b1;
                    lock_q[CL_PR] <= 1'b1;
                    state         <= IDLE;
                end
                SC_RD: state <= SC_ACC;
                SC_ACC: begin
                    acc      <= acc + rdata_ext;
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_idx == LAST_IDX) begin
                        scan_pending <= 1'b0;
                        sum_done_q   <= 1'b1;
                        sum_out_q    <= acc + rdata_ext;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.MEM_WE    = 1'b0;
        bus.MEM_RE    = 1'b0;
        bus.MEM_ADDR  = '0;
        bus.MEM_WDATA = '0;
        bus.WR_ACK    = 1'b0;
        case (state)
            WRITE: begin
                bus.MEM_WE    = 1'b1;
                bus.MEM_ADDR  = bus.WR_ADDR;
                bus.MEM_WDATA = bus.WR_DATA;
                bus.WR_ACK    = 1'b1;
            end
            PR_A: begin
                bus.MEM_RE   = 1'b1;
                bus.MEM_ADDR = a1_q;
            end
            PR_B: begin
                bus.MEM_RE   = 1'b1;
                bus.MEM_ADDR = a2_q;
            end
            SC_RD: begin
                bus.MEM_RE   = 1'b1;
                bus.MEM_ADDR = scan_idx;
            end
            default: ;
        endcase
    end

    assign bus.PR_ACK   = pr_ack_q;
    assign bus.PR_SUM   = pr_sum_q;
    assign bus.SUM_BUSY = scan_pending;
    assign bus.SUM_DONE = sum_done_q;
    assign bus.SUM_OUT  = sum_out_q;

endmodule

// File: tb/tb_sram_share_ctrl.sv
// Bench for sram_share_ctrl: behavioural 8x4 SRAM with one-cycle read latency
// and a queue scoreboard of expected writes, pair sums and scan totals.
module tb_sram_share_ctrl;
    import sram_share_pkg::*;

    localparam int AW = 3;
    localparam int DW = 4;
    localparam int KIND_WR = 0;
    localparam int KIND_PR = 1;
    localparam int KIND_SC = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    logic CLK = 1'b0;
    logic RST;

    sram_share_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    sram_share_ctrl #(.AW(AW), .DW(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] sram [0:(1<<AW)-1];

    always @(posedge CLK) begin
        if (bus.MEM_WE) sram[bus.MEM_ADDR] <= bus.MEM_WDATA;
        if (bus.MEM_RE) bus.MEM_RDATA <= sram[bus.MEM_ADDR];
    end

    wr_exp_t          wr_q [$];
    logic [DW:0]      pr_q [$];
    logic [DW+AW-1:0] sum_q [$];
    wr_exp_t          mon_wr;

    int check_count  = 0;
    int pass_count   = 0;
    int cyc          = 0;
    int wr_count     = 0;
    int pr_ack_count = 0;
    int done_count   = 0;
    int wr_ack_cyc   = 0;
    int pr_ack_cyc   = 0;
    int done_cyc     = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Scoreboard side: every write, pair ack and scan completion must match
    // the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.MEM_WE) begin
                wr_count++;
                wr_ack_cyc = cyc;
                checkOutput("wr_ack_with_we", bus.WR_ACK, 1);
                checkOutput("wr_expected", wr_q.size() > 0, 1);
                if (wr_q.size() > 0) begin
                    mon_wr = wr_q.pop_front();
                    checkOutput("wr_addr", bus.MEM_ADDR, mon_wr.addr);
                    checkOutput("wr_data", bus.MEM_WDATA, mon_wr.data);
                end
            end
            if (bus.PR_ACK) begin
                pr_ack_count++;
                pr_ack_cyc = cyc;
                checkOutput("pr_expected", pr_q.size() > 0, 1);
                if (pr_q.size() > 0) checkOutput("pr_sum", bus.PR_SUM, pr_q.pop_front());
            end
            if (bus.SUM_DONE) begin
                done_count++;
                done_cyc = cyc;
                checkOutput("done_busy_low", bus.SUM_BUSY, 0);
                checkOutput("sum_expected", sum_q.size() > 0, 1);
                if (sum_q.size() > 0) checkOutput("sum_out", bus.SUM_OUT, sum_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input int kind, input int x, input int y, input int expv,
                                 input bit late, output int lat);
        wr_exp_t e;
        lat = 0;
        case (kind)
            KIND_WR: begin
                e.addr = x[AW-1:0];
                e.data = y[DW-1:0];
                wr_q.push_back(e);
                bus.WR_ADDR = x[AW-1:0];
                bus.WR_DATA = y[DW-1:0];
                bus.WR_REQ  = 1'b1;
                do begin
                    @(negedge CLK);
                    lat++;
                end while (!bus.WR_ACK && lat < 200);
                checkOutput("wr_ack_seen", bus.WR_ACK, 1);
                @(posedge CLK); #1;
                if (late) begin
                    @(posedge CLK); #1;
                end
                bus.WR_REQ = 1'b0;
            end
            KIND_PR: begin
                pr_q.push_back(expv[DW:0]);
                bus.PR_A1  = x[AW-1:0];
                bus.PR_A2  = y[AW-1:0];
                bus.PR_REQ = 1'b1;
                do begin
                    @(negedge CLK);
                    lat++;
                end while (!bus.PR_ACK && lat < 200);
                checkOutput("pr_ack_seen", bus.PR_ACK, 1);
                @(posedge CLK); #1;
                bus.PR_REQ = 1'b0;
            end
            default: begin
                if (expv >= 0) sum_q.push_back(expv[DW+AW-1:0]);
                @(posedge CLK); #1;
                bus.SUM_START = 1'b1;
                @(posedge CLK); #1;
                bus.SUM_START = 1'b0;
            end
        endcase
    endtask

    task automatic waitDone(input string tag, input int limit, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus.SUM_DONE && n < limit);
        checkOutput(tag, bus.SUM_DONE, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int lat_w;
        int lat_p;
        int n;
        int acks_before;
        bit found;

        bus.WR_REQ    = 1'b0;
        bus.WR_ADDR   = '0;
        bus.WR_DATA   = '0;
        bus.PR_REQ    = 1'b0;
        bus.PR_A1     = '0;
        bus.PR_A2     = '0;
        bus.SUM_START = 1'b1;
        RST           = 1'b1;

        $display("[TB] reset with SUM_START held");
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_wr_ack", bus.WR_ACK, 0);
        checkOutput("rst_pr_ack", bus.PR_ACK, 0);
        checkOutput("rst_pr_sum", bus.PR_SUM, 0);
        checkOutput("rst_sum_busy", bus.SUM_BUSY, 0);
        checkOutput("rst_sum_done", bus.SUM_DONE, 0);
        checkOutput("rst_sum_out", bus.SUM_OUT, 0);
        checkOutput("rst_mem_we", bus.MEM_WE, 0);
        checkOutput("rst_mem_re", bus.MEM_RE, 0);
        checkOutput("rst_mem_addr", bus.MEM_ADDR, 0);
        checkOutput("rst_mem_wdata", bus.MEM_WDATA, 0);
        @(posedge CLK); #1;
        RST           = 1'b0;
        bus.SUM_START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("start_in_reset_ignored", bus.SUM_BUSY, 0);

        $display("[TB] single write with late REQ drop");
        @(posedge CLK); #1;
        applyStimulus(KIND_WR, 3, 7, 0, 1'b1, lat);
        checkOutput("wr_latency", lat, 2);
        repeat (3) @(negedge CLK);
        checkOutput("single_write", wr_count, 1);

        $display("[TB] pair reads");
        applyStimulus(KIND_WR, 1, 9, 0, 1'b0, lat);
        applyStimulus(KIND_WR, 6, 8, 0, 1'b0, lat);
        applyStimulus(KIND_PR, 1, 6, 17, 1'b0, lat);
        checkOutput("pr_latency", lat, 5);
        applyStimulus(KIND_PR, 1, 1, 18, 1'b0, lat);
        checkOutput("pr_same_addr_latency", lat, 5);

        $display("[TB] full scan with a mid-scan restart attempt");
        for (int i = 0; i < 8; i++) applyStimulus(KIND_WR, i, 9, 0, 1'b0, lat);
        applyStimulus(KIND_SC, 0, 0, 72, 1'b0, lat);
        @(negedge CLK);
        checkOutput("busy_rise", bus.SUM_BUSY, 1);
        n = 0;
        repeat (10) begin
            @(negedge CLK);
            n++;
        end
        bus.SUM_START = 1'b1;
        @(negedge CLK);
        n++;
        bus.SUM_START = 1'b0;
        while (!bus.SUM_DONE && n < 100) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("scan_done_seen", bus.SUM_DONE, 1);
        checkOutput("scan_latency", n, 24);
        repeat (3) @(negedge CLK);
        checkOutput("restart_ignored", bus.SUM_BUSY, 0);

        $display("[TB] write, pair read and scan contending together");
        applyStimulus(KIND_SC, 0, 0, 66, 1'b0, lat);
        fork
            applyStimulus(KIND_WR, 5, 3, 0, 1'b0, lat_w);
            applyStimulus(KIND_PR, 5, 0, 12, 1'b0, lat_p);
        join
        waitDone("prio_done_seen", 100, n);
        @(posedge CLK);
        checkOutput("prio_wr_before_pr", pr_ack_cyc - wr_ack_cyc, 5);
        checkOutput("prio_pr_before_scan", done_cyc - pr_ack_cyc, 24);

        $display("[TB] writes landing during a scan");
        @(posedge CLK); #1;
        applyStimulus(KIND_WR, 5, 9, 0, 1'b0, lat);
        applyStimulus(KIND_SC, 0, 0, 63, 1'b0, lat);
        found = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            @(negedge CLK);
            n++;
            found = bus.MEM_RE && (bus.MEM_ADDR == 3'd4) && bus.SUM_BUSY;
        end
        checkOutput("scan_idx4_seen", found, 1);
        applyStimulus(KIND_WR, 7, 0, 0, 1'b0, lat);
        applyStimulus(KIND_WR, 2, 0, 0, 1'b0, lat);
        waitDone("consist_done_seen", 100, n);

        $display("[TB] reset during a pair read");
        @(posedge CLK); #1;
        bus.SUM_START = 1'b1;
        @(posedge CLK); #1;
        bus.SUM_START = 1'b0;
        bus.PR_A1     = 3'd1;
        bus.PR_A2     = 3'd6;
        bus.PR_REQ    = 1'b1;
        pr_q.push_back(5'd18);
        acks_before = pr_ack_count;
        found = 1'b0;
        n = 0;
        while (!found && n < 50) begin
            @(negedge CLK);
            n++;
            found = bus.MEM_RE && (bus.MEM_ADDR == 3'd6);
        end
        checkOutput("pr_b_seen", found, 1);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("abort_pr_ack", bus.PR_ACK, 0);
        checkOutput("abort_pr_sum", bus.PR_SUM, 0);
        checkOutput("abort_sum_busy", bus.SUM_BUSY, 0);
        checkOutput("abort_mem_re", bus.MEM_RE, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus.PR_ACK && n < 50);
        checkOutput("reserve_pr_latency", n, 5);
        @(posedge CLK); #1;
        bus.PR_REQ = 1'b0;
        repeat (5) @(negedge CLK);
        checkOutput("reserve_single_ack", pr_ack_count - acks_before, 1);
        checkOutput("abort_scan_idle", bus.SUM_BUSY, 0);

        checkOutput("wr_q_drained", wr_q.size(), 0);
        checkOutput("pr_q_drained", pr_q.size(), 0);
        checkOutput("sum_q_drained", sum_q.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
